mtc_pkt_decoder: RTL and testbench

MTC_PKT_DECODER -- requirements
Module: mtc_pkt_decoder

---
 rtl/mtc_pkt_decoder.sv | 186 ++++++++++++++++++
 tb/tb_mtc_pkt_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtc_pkt_decoder.sv
`timescale 1ns/1ps
// MTC-to-SL packet decoder: a one-stage decode register feeding a first-word-fall-through FIFO.
// Optional per-kind and drop statistics are built when MTC_DEC_STATS_EN is defined.
module mtc_pkt_decoder #(
  parameter int MTC_PKT_WIDTH = 128,
  parameter int FIFO_DEPTH = 4,
  localparam int MTC2SL_M_RESERVED_LSB = 0,
  localparam int MTC2SL_M_RESERVED_LEN = 4,
  localparam int MTC2SL_MDT_CHARGE_LSB = 4,
  localparam int MTC2SL_MDT_PROCFLAGS_LSB = 48,
  localparam int MTC2SL_COMMON_LSB = 52,
  localparam int SLC_COMMON_LEN = 76,
  localparam int MDT_W = MTC2SL_MDT_PROCFLAGS_LSB - MTC2SL_MDT_CHARGE_LSB
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [MTC_PKT_WIDTH-1:0]  mtc_i,
  input  logic                      mtc_valid_i,
  output logic [SLC_COMMON_LEN-1:0] dec_common_o,
  output logic [MDT_W-1:0]          dec_mdt_o,
  output logic [3:0]                dec_procflags_o,
  output logic [2:0]                dec_kind_o,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic                      err_reserved_o,
  output logic                      overflow_o
`ifdef MTC_DEC_STATS_EN
  ,
  input  logic                      stats_clr_i,
  output logic [127:0]              stats_o,
  output logic [15:0]               drop_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = SLC_COMMON_LEN + MDT_W + 4 + 3;
  localparam int E_PF_LSB = 3;
  localparam int E_MDT_LSB = 7;
  localparam int E_COM_LSB = 7 + MDT_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

  function automatic logic [2:0] decode_kind(input logic [3:0] pf);
    logic [2:0] k;
    case (pf)
      4'd0:    k = 3'd0;
      4'd1:    k = 3'd1;
      4'd2:    k = 3'd2;
      4'd3:    k = 3'd3;
      4'd4:    k = 3'd4;
      4'd5:    k = 3'd5;
      4'd6:    k = 3'd6;
      default: k = 3'd7;
    endcase
    return k;
  endfunction

  logic               stage_valid_r;
  logic [ENTRY_W-1:0] stage_entry_r;
  logic               err_reserved_r;
  logic               overflow_r;
  logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic               dec_valid_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_en_s;
  logic               drop_s;
  logic [ENTRY_W-1:0] head_s;

  assign dec_valid_s = (count_r != '0);
  assign pop_s       = dec_valid_s & dec_ready_i;
  assign full_s      = (count_r == DEPTH_C);
  // A full FIFO still accepts the write when the head leaves on the same edge.
  assign wr_en_s     = stage_valid_r & (~full_s | pop_s);
  assign drop_s      = stage_valid_r & full_s & ~pop_s;
  assign head_s      = mem_r[rd_ptr_r];

  // Decode stage: capture packet fields and precomputed kind; flag reserved bits.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_r  <= 1'b0;
      stage_entry_r  <= '0;
      err_reserved_r <= 1'b0;
    end else begin
      stage_valid_r  <= mtc_valid_i;
      err_reserved_r <= mtc_valid_i & (|mtc_i[MTC2SL_M_RESERVED_LSB +: MTC2SL_M_RESERVED_LEN]);
      if (mtc_valid_i) begin
        stage_entry_r <= {mtc_i[MTC2SL_COMMON_LSB +: SLC_COMMON_LEN],
                          mtc_i[MTC2SL_MDT_CHARGE_LSB +: MDT_W],
                          mtc_i[MTC2SL_MDT_PROCFLAGS_LSB +: 4],
                          decode_kind(mtc_i[MTC2SL_MDT_PROCFLAGS_LSB +: 4])};
      end
    end
  end

  // FIFO storage; contents are don't-care until covered by count_r.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= stage_entry_r;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Head entry fields, forced to zero whenever nothing is presented.
  always_comb begin
    dec_common_o    = '0;
    dec_mdt_o       = '0;
    dec_procflags_o = 4'd0;
    dec_kind_o      = 3'd0;
    if (dec_valid_s) begin
      dec_common_o    = head_s[E_COM_LSB +: SLC_COMMON_LEN];
      dec_mdt_o       = head_s[E_MDT_LSB +: MDT_W];
      dec_procflags_o = head_s[E_PF_LSB +: 4];
      dec_kind_o      = head_s[2:0];
    end else begin
      dec_common_o    = '0;
      dec_mdt_o       = '0;
      dec_procflags_o = 4'd0;
      dec_kind_o      = 3'd0;
    end
  end

  assign dec_valid_o    = dec_valid_s;
  assign err_reserved_o = err_reserved_r;
  assign overflow_o     = overflow_r;

`ifdef MTC_DEC_STATS_EN
  logic [15:0] kind_cnt_r [8];
  logic [15:0] drop_cnt_r;
  logic [2:0]  wr_kind_s;

  assign wr_kind_s = stage_entry_r[2:0];

  // Saturating counters; clear wins over increment.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) kind_cnt_r[k] <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else if (stats_clr_i) begin
      for (int k = 0; k < 8; k++) kind_cnt_r[k] <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (wr_en_s && (kind_cnt_r[wr_kind_s] != 16'hFFFF)) begin
        kind_cnt_r[wr_kind_s] <= kind_cnt_r[wr_kind_s] + 16'd1;
      end
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_stats
    assign stats_o[16*g +: 16] = kind_cnt_r[g];
  end
  assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_mtc_pkt_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for mtc_pkt_decoder: kind table, latency, overflow, full-with-pop, reset.
module tb_mtc_pkt_decoder;

  localparam int COM_W = 76;
  localparam int MDT_W = 44;

  logic             clock = 1'b0;
  logic             rst_n;
  logic [127:0]     mtc_i;
  logic             mtc_valid_i;
  logic [COM_W-1:0] dec_common_o;
  logic [MDT_W-1:0] dec_mdt_o;
  logic [3:0]       dec_procflags_o;
  logic [2:0]       dec_kind_o;
  logic             dec_valid_o;
  logic             dec_ready_i;
  logic             err_reserved_o;
  logic             overflow_o;
`ifdef MTC_DEC_STATS_EN
  logic             stats_clr_i;
  logic [127:0]     stats_o;
  logic [15:0]      drop_cnt_o;
`endif

  mtc_pkt_decoder dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .mtc_i           (mtc_i),
    .mtc_valid_i     (mtc_valid_i),
    .dec_common_o    (dec_common_o),
    .dec_mdt_o       (dec_mdt_o),
    .dec_procflags_o (dec_procflags_o),
    .dec_kind_o      (dec_kind_o),
    .dec_valid_o     (dec_valid_o),
    .dec_ready_i     (dec_ready_i),
    .err_reserved_o  (err_reserved_o),
    .overflow_o      (overflow_o)
`ifdef MTC_DEC_STATS_EN
    ,
    .stats_clr_i     (stats_clr_i),
    .stats_o         (stats_o),
    .drop_cnt_o      (drop_cnt_o)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [COM_W-1:0] common;
    logic [MDT_W-1:0] mdt;
    logic [3:0]       pf;
    logic [2:0]       kind;
  } ent_t;

  typedef struct {
    logic [3:0] pf;
    logic [2:0] kind;
  } vec_t;

  ent_t sb_q[$];
  ent_t cur_s;
  ent_t held;
  bit   held_v = 1'b0;
  int   checks = 0;
  int   errors = 0;

  assign cur_s = {dec_common_o, dec_mdt_o, dec_procflags_o, dec_kind_o};

  function automatic logic [2:0] model_kind(input logic [3:0] pf);
    if (pf > 4'd6) return 3'd7;
    return pf[2:0];
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ent(input string name, input ent_t act, input ent_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got kind=%0d pf=%0h mdt=%0h com=%0h expected kind=%0d pf=%0h mdt=%0h com=%0h at %0t",
               name, act.kind, act.pf, act.mdt, act.common, exp.kind, exp.pf, exp.mdt, exp.common, $time);
    end
  endtask

  // Drive one packet for one cycle starting at a falling edge; returns at the next falling edge.
  task automatic send(input logic [3:0] pf, input logic [3:0] res, input bit store, input logic [2:0] kind);
    logic [COM_W-1:0] c;
    logic [MDT_W-1:0] m;
    ent_t e;
    c = COM_W'({$urandom, $urandom, $urandom});
    m = MDT_W'({$urandom, $urandom});
    mtc_i = {c, pf, m, res};
    mtc_valid_i = 1'b1;
    e = '{common: c, mdt: m, pf: pf, kind: kind};
    if (store) sb_q.push_back(e);
    @(negedge clock);
    mtc_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    dec_ready_i = 1'b1;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clock);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d entries outstanding expected 0", name, sb_q.size());
    end
  endtask

  // Scoreboard monitor: hold stability while stalled, in-order compare on each pop.
  always @(negedge clock) begin
    #1;
    if (rst_n) begin
      if (held_v) begin
        chk_bit("hold_valid", dec_valid_o, 1'b1);
        chk_ent("hold_data", cur_s, held);
      end
      if (dec_valid_o && dec_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got kind=%0d expected no entry", dec_kind_o);
        end else begin
          chk_ent("entry", cur_s, sb_q.pop_front());
        end
      end
      held_v = dec_valid_o && !dec_ready_i;
      held   = cur_s;
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{pf: 4'd0, kind: 3'd0};
    vecs[1] = '{pf: 4'd2, kind: 3'd2};
    vecs[2] = '{pf: 4'd3, kind: 3'd3};
    vecs[3] = '{pf: 4'd4, kind: 3'd4};
    vecs[4] = '{pf: 4'd5, kind: 3'd5};
    vecs[5] = '{pf: 4'd6, kind: 3'd6};
    vecs[6] = '{pf: 4'hF, kind: 3'd7};
    vecs[7] = '{pf: 4'd1, kind: 3'd1};
    vecs[8] = '{pf: 4'd7, kind: 3'd7};
    vecs[9] = '{pf: 4'd9, kind: 3'd7};

    rst_n = 1'b0;
    mtc_i = 128'd0;
    mtc_valid_i = 1'b0;
    dec_ready_i = 1'b0;
`ifdef MTC_DEC_STATS_EN
    stats_clr_i = 1'b0;
`endif
    #1;
    chk_bit("rst_valid", dec_valid_o, 1'b0);
    chk_ent("rst_outputs", cur_s, '0);
    chk_bit("rst_overflow", overflow_o, 1'b0);
    chk_bit("rst_err", err_reserved_o, 1'b0);
`ifdef MTC_DEC_STATS_EN
    chk16("rst_drop_cnt", drop_cnt_o, 16'd0);
`endif
    repeat (2) @(negedge clock);
    rst_n = 1'b1;

    // Single packet, two-cycle latency, one-cycle valid.
    @(negedge clock);
    dec_ready_i = 1'b1;
    send(4'd1, 4'd0, 1'b1, 3'd1);
    #1;
    chk_bit("lat_c1_valid", dec_valid_o, 1'b0);
    chk_bit("lat_c1_err", err_reserved_o, 1'b0);
    @(negedge clock); #1;
    chk_bit("lat_c2_valid", dec_valid_o, 1'b1);
    chk_bit("lat_c2_kind", dec_kind_o == 3'd1, 1'b1);
    @(negedge clock); #1;
    chk_bit("lat_c3_valid", dec_valid_o, 1'b0);

    // Reserved bits set: pulse in cycle 1, packet still delivered.
    @(negedge clock);
    send(4'd1, 4'hA, 1'b1, 3'd1);
    #1;
    chk_bit("err_c1", err_reserved_o, 1'b1);
    @(negedge clock); #1;
    chk_bit("err_c2", err_reserved_o, 1'b0);
    @(negedge clock);
    drain("reserved");

    // Kind table, back to back.
    @(negedge clock);
    for (int i = 0; i < 10; i++) send(vecs[i].pf, 4'd0, 1'b1, vecs[i].kind);
    drain("kinds");

    // Overflow: 6 packets into a stalled depth-4 FIFO.
    @(negedge clock);
`ifdef MTC_DEC_STATS_EN
    stats_clr_i = 1'b1;
    @(negedge clock);
    stats_clr_i = 1'b0;
    #1;
    chk16("clr_kind1", stats_o[16 +: 16], 16'd0);
    @(negedge clock);
`endif
    dec_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) send(4'd5, 4'd0, i < 4, model_kind(4'd5));
    repeat (2) @(negedge clock);
    #1;
    chk_bit("ovf_flag", overflow_o, 1'b1);
    chk_bit("ovf_valid", dec_valid_o, 1'b1);
`ifdef MTC_DEC_STATS_EN
    chk16("ovf_drop_cnt", drop_cnt_o, 16'd2);
    chk16("ovf_kind5", stats_o[5*16 +: 16], 16'd4);
`endif
    @(negedge clock);
    drain("overflow");
    chk_bit("ovf_sticky", overflow_o, 1'b1);

    @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;

    // Full FIFO with a write and a pop on the same edge.
    @(negedge clock);
    dec_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd2, 4'd0, 1'b1, model_kind(4'd2));
    send(4'd3, 4'd0, 1'b1, model_kind(4'd3));
    dec_ready_i = 1'b1;
    @(negedge clock);
    dec_ready_i = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk_bit("fullpop_overflow", overflow_o, 1'b0);
    chk_bit("fullpop_valid", dec_valid_o, 1'b1);
`ifdef MTC_DEC_STATS_EN
    chk16("fullpop_drop_cnt", drop_cnt_o, 16'd0);
`endif
    @(negedge clock);
    drain("fullpop");

    // Reset mid-burst with three entries buffered and a packet arriving.
    @(negedge clock);
    dec_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(4'(i + 4), 4'd0, 1'b1, model_kind(4'(i + 4)));
    @(negedge clock);
    mtc_i = {32'hDEAD_BEEF, 96'd1};
    mtc_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    mtc_valid_i = 1'b0;
    #1;
    chk_bit("midrst_valid", dec_valid_o, 1'b0);
    chk_bit("midrst_overflow", overflow_o, 1'b0);
`ifdef MTC_DEC_STATS_EN
    chk16("midrst_drop_cnt", drop_cnt_o, 16'd0);
    chk16("midrst_kind4", stats_o[4*16 +: 16], 16'd0);
`endif
    rst_n = 1'b1;
    sb_q.delete();
    held_v = 1'b0;
    @(negedge clock);
    dec_ready_i = 1'b1;
    send(4'd4, 4'd0, 1'b1, model_kind(4'd4));
    #1;
    chk_bit("postrst_c1_valid", dec_valid_o, 1'b0);
    @(negedge clock); #1;
    chk_bit("postrst_c2_valid", dec_valid_o, 1'b1);
    @(negedge clock);
    drain("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
